// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: FSM states, ALU op codes, opcode/ext fields, condition codes, PSR bit indices, reg-op decode helper
package cpu_controller_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_LD_WB, S_MEM_WR, S_HALT} state_t;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_XOR = 4'd3, ALU_OR = 4'd4;
  localparam logic [3:0] ALU_CMP = 4'd5, ALU_MOV = 4'd6, ALU_LSH = 4'd7, ALU_LSHI = 4'd8, ALU_LUI = 4'd9;
  localparam logic [3:0] OP_REG = 4'h0, OP_MEM = 4'h4, OP_SHIFT = 4'h8, OP_BCOND = 4'hC, OP_LUI = 4'hF;
  localparam logic [3:0] EXT_ADD = 4'h5, EXT_SUB = 4'h9, EXT_CMP = 4'hB, EXT_AND = 4'h1;
  localparam logic [3:0] EXT_OR = 4'h2, EXT_XOR = 4'h3, EXT_MOV = 4'hD;
  localparam logic [3:0] EXT_LOAD = 4'h0, EXT_STOR = 4'h4, EXT_JAL = 4'h8, EXT_JCOND = 4'hC;
  localparam logic [3:0] EXT_LSH = 4'h4, EXT_LSHI0 = 4'h0, EXT_LSHI1 = 4'h1;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3, CC_HI = 4'h4, CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6, CC_LE = 4'h7, CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF;
  localparam int PSR_C = 0, PSR_F = 1, PSR_L = 2, PSR_Z = 3, PSR_N = 4;
  localparam logic [1:0] PC_INC = 2'd0, PC_DISP = 2'd1, PC_REG = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC1 = 2'd2;
  function automatic logic [4:0] rr_decode(input logic [3:0] code);
    case (code)
      EXT_ADD: return {1'b1, ALU_ADD};
      EXT_SUB: return {1'b1, ALU_SUB};
      EXT_CMP: return {1'b1, ALU_CMP};
      EXT_AND: return {1'b1, ALU_AND};
      EXT_OR:  return {1'b1, ALU_OR};
      EXT_XOR: return {1'b1, ALU_XOR};
      EXT_MOV: return {1'b1, ALU_MOV};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction
endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: controller/datapath bundle; master = controller (instr, psr_in, mem_ready in; strobes, flags, halted out), slave = datapath side
interface cpu_controller_if;
  logic [15:0] instr;
  logic [4:0]  psr_in;
  logic        mem_ready;
  logic [3:0]  alucont;
  logic        imm_sel;
  logic        imm_zext;
  logic        ir_we;
  logic        pc_en;
  logic        reg_we;
  logic [1:0]  pc_sel;
  logic [1:0]  wb_sel;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [4:0]  flags;
  logic        halted;
  modport master (
    input  instr, psr_in, mem_ready,
    output alucont, imm_sel, imm_zext, ir_we, pc_en, reg_we, pc_sel, wb_sel,
    output mem_req, mem_we, mem_addr_sel, flags, halted
  );
  modport slave (
    output instr, psr_in, mem_ready,
    input  alucont, imm_sel, imm_zext, ir_we, pc_en, reg_we, pc_sel, wb_sel,
    input  mem_req, mem_we, mem_addr_sel, flags, halted
  );
endinterface

// File: rtl/cpu_controller_cond_eval.sv
// cond_eval: branch condition decode; cond (4b Rdest field) and flags (5b PSR) in, taken out
module cond_eval
  import cpu_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);
  logic c, f, l, z, n;
  logic [15:0] tbl;
  assign c = flags[PSR_C];
  assign f = flags[PSR_F];
  assign l = flags[PSR_L];
  assign z = flags[PSR_Z];
  assign n = flags[PSR_N];
  assign tbl = {1'b0, 1'b1, n | z, !n && !z, l | z, !l && !z, !f, f, !n, n, !l, l, !c, c, !z, z};
  assign taken = tbl[cond];
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multicycle control FSM; clk, reset (async high), bus (cpu_controller_if.master) carries instr/psr_in/mem_ready in and ALU/PC/regfile/memory strobes, flags, halted out
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.master bus
);
  state_t state_q, state_d;
  logic [4:0] flags_q, flags_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] op, ext, alu_op, rr_alu;
  logic rr_ok, is_shift, is_alu, imm_form, logic_imm, sets_flags;
  logic is_load, is_stor, is_jal, is_jcond, is_bcond, legal, taken;
  assign op = bus.instr[15:12];
  assign ext = bus.instr[7:4];
  // immediate forms reuse the register-form ext value as their opcode
  assign {rr_ok, rr_alu} = rr_decode(op == OP_REG ? ext : op);
  assign is_shift = op == OP_SHIFT && (ext == EXT_LSH || ext == EXT_LSHI0 || ext == EXT_LSHI1);
  assign is_alu = rr_ok || is_shift || op == OP_LUI;
  assign alu_op = op == OP_LUI ? ALU_LUI : is_shift ? (ext == EXT_LSH ? ALU_LSH : ALU_LSHI) : rr_alu;
  assign imm_form = is_alu && op != OP_REG && !(is_shift && ext == EXT_LSH);
  assign logic_imm = imm_form && (alu_op == ALU_AND || alu_op == ALU_OR || alu_op == ALU_XOR);
  assign sets_flags = is_alu && (alu_op == ALU_ADD || alu_op == ALU_SUB || alu_op == ALU_CMP);
  assign is_load = op == OP_MEM && ext == EXT_LOAD;
  assign is_stor = op == OP_MEM && ext == EXT_STOR;
  assign is_jal = op == OP_MEM && ext == EXT_JAL;
  assign is_jcond = op == OP_MEM && ext == EXT_JCOND;
  assign is_bcond = op == OP_BCOND;
  assign legal = is_alu || is_load || is_stor || is_jal || is_jcond || is_bcond;
  assign bus.flags = flags_q;
  assign bus.halted = state_q == S_HALT;
  cond_eval u_cond_eval (.cond(bus.instr[11:8]), .flags(flags_q), .taken(taken));
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    wait_d = wait_q;
    bus.alucont = ALU_ADD;
    bus.imm_sel = 1'b0;
    bus.imm_zext = 1'b0;
    bus.ir_we = 1'b0;
    bus.pc_en = 1'b0;
    bus.reg_we = 1'b0;
    bus.pc_sel = PC_INC;
    bus.wb_sel = WB_ALU;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr_sel = 1'b0;
    case (state_q)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        // reset forces FETCH, so gate the request to drop it while reset is held
        bus.mem_req = !reset;
        bus.mem_addr_sel = state_q != S_FETCH;
        bus.mem_we = state_q == S_MEM_WR;
        if (bus.mem_ready) begin
          bus.ir_we = state_q == S_FETCH;
          bus.pc_en = state_q == S_MEM_WR;
          state_d = state_q == S_FETCH ? S_DECODE : state_q == S_MEM_RD ? S_LD_WB : S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
          state_d = wait_d == 8'(WAIT_MAX) ? S_HALT : state_q;
        end
      end
      S_DECODE: state_d = is_load ? S_MEM_RD : is_stor ? S_MEM_WR : legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        state_d = S_FETCH;
        bus.pc_en = 1'b1;
        if (is_alu) begin
          bus.alucont = alu_op;
          bus.imm_sel = imm_form;
          bus.imm_zext = logic_imm;
          bus.reg_we = alu_op != ALU_CMP;
          flags_d = sets_flags ? bus.psr_in : flags_q;
        end else if (is_jal) begin
          bus.reg_we = 1'b1;
          bus.wb_sel = WB_PC1;
          bus.pc_sel = PC_REG;
        end else if (taken) begin
          bus.pc_sel = is_bcond ? PC_DISP : PC_REG;
        end
      end
      S_LD_WB: begin
        state_d = S_FETCH;
        bus.reg_we = 1'b1;
        bus.wb_sel = WB_MEM;
        bus.pc_en = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM_RD || state_d == S_MEM_WR)) wait_d = '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      wait_q <= wait_d;
    end
  end
endmodule
